// File: rtl/adc_spi_responder.sv
// adc_spi_responder: SPI responder that stands in for the preamp gain register
// and the dual-channel ADC frame on the acquisition SPI bus. Every SPI input is
// oversampled in the clk domain. Nothing in this block is clocked by SPI_SCK.
//
// Optional feature macro: ADC_RESP_RAMP_EN. When it is defined, the samples
// come from an internal ramp instead of the sample_a/sample_b ports.
//
// Ports:
//   clk, rst           system clock; asynchronous active-low reset
//   SPI_SCK, SPI_MOSI  SPI clock and preamp gain data (MSB first)
//   AMP_CS             preamp chip select, active-low
//   AMP_SHDN           preamp shutdown, active-high
//   AD_CONV            conversion start, taken on the rising edge
//   sample_a/_b        channel A/B samples, two's complement
//   AMP_DOUT           echo of the previous gain word, MSB first
//   AD_DOUT            ADC serial frame data
//   gain_a/_b          latched gain codes
//   gain_valid         one-clk pulse when a new gain word is latched
//   conv_count         number of completed ADC frames (wraps)
//   frame_err          one-clk pulse on a short or aborted frame
module adc_spi_responder #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DATA_W      = 14,
   parameter int unsigned RAMP_STEP   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SPI_SCK,
   input  logic              SPI_MOSI,
   input  logic              AMP_CS,
   input  logic              AMP_SHDN,
   input  logic              AD_CONV,
   input  logic [DATA_W-1:0] sample_a,
   input  logic [DATA_W-1:0] sample_b,
   output logic              AMP_DOUT,
   output logic              AD_DOUT,
   output logic [3:0]        gain_a,
   output logic [3:0]        gain_b,
   output logic              gain_valid,
   output logic [15:0]       conv_count,
   output logic              frame_err
);

   localparam int unsigned FRAME_LEN = 2 * DATA_W + 6;
   localparam int unsigned FCNT_W    = $clog2(FRAME_LEN + 1);
   // Bit order of the synchronized bundle: {shdn, conv, cs, mosi, sck}.
   // CS idles high, so its synchronizer stages reset to 1.
   localparam logic [SYNC_STAGES-1:0][4:0] SYNC_RST = {SYNC_STAGES{5'b00100}};

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
   end
   if (RAMP_STEP == 0) begin : g_bad_step
      $error("RAMP_STEP must be nonzero");
   end

   typedef enum logic {AMP_IDLE, AMP_SHIFT} amp_state_t;
   typedef enum logic {ADC_IDLE, ADC_FRAME} adc_state_t;

   // Input synchronizers and edge detection
   logic [SYNC_STAGES-1:0][4:0] sync_q;
   logic sck_s, mosi_s, cs_s, conv_s, shdn_s;
   logic sck_q, cs_q, conv_q;
   logic sck_rise, sck_fall, conv_rise, cs_fall, cs_rise;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= SYNC_RST;
         sck_q  <= 1'b0;
         cs_q   <= 1'b1;
         conv_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], {AMP_SHDN, AD_CONV, AMP_CS, SPI_MOSI, SPI_SCK}};
         sck_q  <= sck_s;
         cs_q   <= cs_s;
         conv_q <= conv_s;
      end
   end

   assign {shdn_s, conv_s, cs_s, mosi_s, sck_s} = sync_q[SYNC_STAGES-1];
   assign sck_rise  =  sck_s  & ~sck_q;
   assign sck_fall  = ~sck_s  &  sck_q;
   assign conv_rise =  conv_s & ~conv_q;
   assign cs_fall   = ~cs_s   &  cs_q;
   assign cs_rise   =  cs_s   & ~cs_q;

   // Preamp gain register FSM
   amp_state_t amp_state, amp_state_nxt;
   logic [7:0] shift_in, shift_in_nxt, shift_out, shift_out_nxt;
   logic [3:0] bit_cnt, bit_cnt_nxt;
   logic [3:0] gain_a_nxt, gain_b_nxt;
   logic       amp_dout_nxt, gain_valid_nxt, amp_err;

   always_comb begin
      amp_state_nxt  = amp_state;
      shift_in_nxt   = shift_in;
      shift_out_nxt  = shift_out;
      bit_cnt_nxt    = bit_cnt;
      gain_a_nxt     = gain_a;
      gain_b_nxt     = gain_b;
      amp_dout_nxt   = AMP_DOUT;
      gain_valid_nxt = 1'b0;
      amp_err        = 1'b0;
      if (shdn_s) begin
         amp_state_nxt = AMP_IDLE;
         gain_a_nxt    = 4'd0;
         gain_b_nxt    = 4'd0;
         amp_dout_nxt  = 1'b0;
      end else begin
         case (amp_state)
            AMP_IDLE: begin
               if (cs_fall) begin
                  shift_out_nxt = {gain_b, gain_a};
                  shift_in_nxt  = 8'd0;
                  bit_cnt_nxt   = 4'd0;
                  amp_dout_nxt  = gain_b[3];
                  amp_state_nxt = AMP_SHIFT;
               end
            end
            AMP_SHIFT: begin
               if (cs_rise) begin
                  if (bit_cnt == 4'd8) begin
                     gain_b_nxt     = shift_in[7:4];
                     gain_a_nxt     = shift_in[3:0];
                     gain_valid_nxt = 1'b1;
                  end else begin
                     amp_err = 1'b1;
                  end
                  amp_dout_nxt  = 1'b0;
                  amp_state_nxt = AMP_IDLE;
               end else begin
                  if (sck_rise) begin
                     shift_in_nxt = {shift_in[6:0], mosi_s};
                     if (bit_cnt != 4'd15) bit_cnt_nxt = bit_cnt + 4'd1;
                  end
                  if (sck_fall) begin
                     shift_out_nxt = {shift_out[6:0], 1'b0};
                     amp_dout_nxt  = shift_out[6];
                  end
               end
            end
            default: amp_state_nxt = AMP_IDLE;
         endcase
      end
   end

   // Sample source: ports, or the internal ramp (B is the negated ramp)
   logic [DATA_W-1:0] src_a, src_b, lat_a, lat_b;
   logic              frame_done;
`ifdef ADC_RESP_RAMP_EN
   logic [DATA_W-1:0] ramp;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)            ramp <= '0;
      else if (frame_done) ramp <= ramp + DATA_W'(RAMP_STEP);
   end

   assign src_a = ramp;
   assign src_b = DATA_W'(-ramp);
`else
   assign src_a = sample_a;
   assign src_b = sample_b;
`endif
   assign lat_a = shdn_s ? '0 : src_a;
   assign lat_b = shdn_s ? '0 : src_b;

   // ADC frame FSM. The frame shifter holds {00, A, 00, B, 00}, so each
   // counted SCK fall presents the next bit MSB first.
   adc_state_t adc_state, adc_state_nxt;
   logic [FCNT_W-1:0]    fall_cnt, fall_cnt_nxt;
   logic [FRAME_LEN-1:0] frame_sr, frame_sr_nxt;
   logic [15:0]          conv_count_nxt;
   logic                 ad_dout_nxt, adc_err;

   always_comb begin
      adc_state_nxt  = adc_state;
      fall_cnt_nxt   = fall_cnt;
      frame_sr_nxt   = frame_sr;
      conv_count_nxt = conv_count;
      ad_dout_nxt    = AD_DOUT;
      adc_err        = 1'b0;
      frame_done     = 1'b0;
      if (conv_rise) begin
         adc_err       = (adc_state == ADC_FRAME);
         frame_sr_nxt  = {2'b00, lat_a, 2'b00, lat_b, 2'b00};
         fall_cnt_nxt  = '0;
         ad_dout_nxt   = 1'b0;
         adc_state_nxt = ADC_FRAME;
      end else begin
         case (adc_state)
            ADC_IDLE: ;
            ADC_FRAME: begin
               // SCK activity while the preamp is selected belongs to the preamp.
               if (sck_fall && cs_s) begin
                  ad_dout_nxt  = frame_sr[FRAME_LEN-1];
                  frame_sr_nxt = {frame_sr[FRAME_LEN-2:0], 1'b0};
                  fall_cnt_nxt = fall_cnt + FCNT_W'(1);
                  if (fall_cnt_nxt == FCNT_W'(FRAME_LEN)) begin
                     conv_count_nxt = conv_count + 16'd1;
                     ad_dout_nxt    = 1'b0;
                     frame_done     = 1'b1;
                     adc_state_nxt  = ADC_IDLE;
                  end
               end
            end
            default: adc_state_nxt = ADC_IDLE;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         amp_state  <= AMP_IDLE;
         shift_in   <= 8'd0;
         shift_out  <= 8'd0;
         bit_cnt    <= 4'd0;
         gain_a     <= 4'd0;
         gain_b     <= 4'd0;
         AMP_DOUT   <= 1'b0;
         gain_valid <= 1'b0;
         adc_state  <= ADC_IDLE;
         fall_cnt   <= '0;
         frame_sr   <= '0;
         conv_count <= 16'd0;
         AD_DOUT    <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         amp_state  <= amp_state_nxt;
         shift_in   <= shift_in_nxt;
         shift_out  <= shift_out_nxt;
         bit_cnt    <= bit_cnt_nxt;
         gain_a     <= gain_a_nxt;
         gain_b     <= gain_b_nxt;
         AMP_DOUT   <= amp_dout_nxt;
         gain_valid <= gain_valid_nxt;
         adc_state  <= adc_state_nxt;
         fall_cnt   <= fall_cnt_nxt;
         frame_sr   <= frame_sr_nxt;
         conv_count <= conv_count_nxt;
         AD_DOUT    <= ad_dout_nxt;
         frame_err  <= amp_err | adc_err;
      end
   end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: serial bits are checked through an
// expected/observed scoreboard, and pulse outputs through counters.
module tb_adc_spi_responder;
   localparam int unsigned DATA_W = 14;
   localparam int unsigned HALF   = 6;

   logic clk = 1'b0, rst = 1'b0;
   logic SPI_SCK = 1'b0, SPI_MOSI = 1'b0, AMP_CS = 1'b1, AMP_SHDN = 1'b0, AD_CONV = 1'b0;
   logic [DATA_W-1:0] sample_a = '0, sample_b = '0;
   logic AMP_DOUT, AD_DOUT, gain_valid, frame_err;
   logic [3:0] gain_a, gain_b;
   logic [15:0] conv_count;

   int n_checks = 0, n_fail = 0;
   int gv_cnt = 0, err_cnt = 0;
   logic exp_q[$];
   logic obs_q[$];
   logic [3:0] m_ga = 4'd0, m_gb = 4'd0;
   logic [15:0] m_cnt = 16'd0;
   logic [DATA_W-1:0] m_ramp = '0;

   adc_spi_responder #(.SYNC_STAGES(2), .DATA_W(DATA_W), .RAMP_STEP(16)) dut (
      .clk(clk), .rst(rst), .SPI_SCK(SPI_SCK), .SPI_MOSI(SPI_MOSI), .AMP_CS(AMP_CS),
      .AMP_SHDN(AMP_SHDN), .AD_CONV(AD_CONV), .sample_a(sample_a), .sample_b(sample_b),
      .AMP_DOUT(AMP_DOUT), .AD_DOUT(AD_DOUT), .gain_a(gain_a), .gain_b(gain_b),
      .gain_valid(gain_valid), .conv_count(conv_count), .frame_err(frame_err));

   always #5 clk = ~clk;

   // Counted at negedge so a one-clk pulse adds exactly one.
   always @(negedge clk) begin
      if (gain_valid === 1'b1) gv_cnt++;
      if (frame_err === 1'b1) err_cnt++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sck_pulse();
      SPI_SCK = 1'b1; wait_clk(HALF);
      SPI_SCK = 1'b0; wait_clk(HALF);
   endtask

   // Preamp transfer; AMP_DOUT is recorded at the end of every low phase.
   task automatic amp_xfer(input logic [7:0] word, input int nbits);
      AMP_CS = 1'b0; wait_clk(HALF);
      for (int i = 0; i < nbits; i++) begin
         obs_q.push_back(AMP_DOUT);
         SPI_MOSI = word[7-i];
         wait_clk(1);
         sck_pulse();
      end
      AMP_CS = 1'b1; wait_clk(HALF);
   endtask

   task automatic adc_conv();
      AD_CONV = 1'b1; wait_clk(5);
      AD_CONV = 1'b0; wait_clk(HALF);
   endtask

   task automatic adc_falls(input int n);
      for (int i = 0; i < n; i++) begin
         sck_pulse();
         obs_q.push_back(AD_DOUT);
      end
   endtask

   // Reference frame: bit k (1-based) of the 34-bit ADC frame.
   function automatic logic frame_bit(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                      input int k);
      if (k >= 3 && k <= 16) return a[16-k];
      if (k >= 19 && k <= 32) return b[32-k];
      return 1'b0;
   endfunction

   task automatic push_frame(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                             input int first, input int last);
      for (int k = first; k <= last; k++) exp_q.push_back(frame_bit(a, b, k));
   endtask

   task automatic push_echo(input int nbits);
      logic [7:0] w;
      w = {m_gb, m_ga};
      for (int i = 0; i < nbits; i++) exp_q.push_back(w[7-i]);
   endtask

   task automatic model_latch(output logic [DATA_W-1:0] a, output logic [DATA_W-1:0] b);
`ifdef ADC_RESP_RAMP_EN
      a = m_ramp; b = DATA_W'(-m_ramp);
`else
      a = sample_a; b = sample_b;
`endif
      if (AMP_SHDN) begin a = '0; b = '0; end
   endtask

   task automatic model_frame_done();
      m_cnt++;
      m_ramp = m_ramp + DATA_W'(16);
   endtask

   task automatic test_reset();
      wait_clk(3);
      n_checks++; if (AMP_DOUT !== 1'b0) begin n_fail++; $display("FAIL reset AMP_DOUT: got %b expected 0", AMP_DOUT); end
      n_checks++; if (AD_DOUT !== 1'b0) begin n_fail++; $display("FAIL reset AD_DOUT: got %b expected 0", AD_DOUT); end
      n_checks++; if ({gain_b, gain_a} !== 8'h00) begin n_fail++; $display("FAIL reset gains: got %h expected 00", {gain_b, gain_a}); end
      n_checks++; if (gain_valid !== 1'b0) begin n_fail++; $display("FAIL reset gain_valid: got %b expected 0", gain_valid); end
      n_checks++; if (conv_count !== 16'd0) begin n_fail++; $display("FAIL reset conv_count: got %0d expected 0", conv_count); end
      n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset frame_err: got %b expected 0", frame_err); end
      rst = 1'b1; wait_clk(5);
   endtask

`ifdef ADC_RESP_RAMP_EN
   task automatic test_ramp();
      logic [DATA_W-1:0] ra [3];
      logic [DATA_W-1:0] rb [3];
      logic e, o;
      int idx;
      ra[0] = 14'h0000; ra[1] = 14'h0010; ra[2] = 14'h0020;
      rb[0] = 14'h0000; rb[1] = 14'h3FF0; rb[2] = 14'h3FE0;
      sample_a = 14'h1111; sample_b = 14'h2222;
      for (int f = 0; f < 3; f++) begin
         push_frame(ra[f], rb[f], 1, 34);
         adc_conv(); adc_falls(34);
         model_frame_done();
      end
      idx = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL ramp bit %0d: got %b expected %b", idx, o, e); end
         idx++;
      end
      n_checks++; if (conv_count !== m_cnt) begin n_fail++; $display("FAIL ramp conv_count: got %0d expected %0d", conv_count, m_cnt); end
   endtask
`endif

   task automatic test_gain_write();
      int gv0, er0, idx;
      logic e, o;
      gv0 = gv_cnt; er0 = err_cnt;
      push_echo(8); amp_xfer(8'h91, 8);
      m_gb = 4'h9; m_ga = 4'h1;
      n_checks++; if (gain_b !== 4'h9 || gain_a !== 4'h1) begin n_fail++; $display("FAIL gain write 91: got %h%h expected 91", gain_b, gain_a); end
      n_checks++; if (gv_cnt - gv0 != 1) begin n_fail++; $display("FAIL gain write valid pulses: got %0d expected 1", gv_cnt - gv0); end
      // Short write: 5 bits only.
      gv0 = gv_cnt; er0 = err_cnt;
      push_echo(5); amp_xfer(8'hA5, 5);
      n_checks++; if (err_cnt - er0 != 1) begin n_fail++; $display("FAIL short write frame_err pulses: got %0d expected 1", err_cnt - er0); end
      n_checks++; if (gv_cnt - gv0 != 0) begin n_fail++; $display("FAIL short write valid pulses: got %0d expected 0", gv_cnt - gv0); end
      n_checks++; if ({gain_b, gain_a} !== 8'h91) begin n_fail++; $display("FAIL short write gains: got %h expected 91", {gain_b, gain_a}); end
      // Full write that also echoes 91.
      er0 = err_cnt;
      push_echo(8); amp_xfer(8'h3C, 8);
      m_gb = 4'h3; m_ga = 4'hC;
      n_checks++; if ({gain_b, gain_a} !== 8'h3C) begin n_fail++; $display("FAIL gain write 3C: got %h expected 3C", {gain_b, gain_a}); end
      n_checks++; if (err_cnt != er0) begin n_fail++; $display("FAIL gain write frame_err pulses: got %0d expected 0", err_cnt - er0); end
      idx = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL echo bit %0d: got %b expected %b", idx, o, e); end
         idx++;
      end
   endtask

   task automatic test_adc_frame();
      logic [DATA_W-1:0] a, b;
      logic e, o;
      int er0, idx;
      er0 = err_cnt;
      sample_a = 14'h2AAA; sample_b = 14'h1555;
      model_latch(a, b);
      push_frame(a, b, 1, 34);
      adc_conv(); adc_falls(34);
      model_frame_done();
      idx = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL adc frame bit %0d: got %b expected %b", idx + 1, o, e); end
         idx++;
      end
      n_checks++; if (conv_count !== m_cnt) begin n_fail++; $display("FAIL adc frame conv_count: got %0d expected %0d", conv_count, m_cnt); end
      n_checks++; if (err_cnt != er0) begin n_fail++; $display("FAIL adc frame frame_err pulses: got %0d expected 0", err_cnt - er0); end
   endtask

   task automatic test_abort();
      logic [DATA_W-1:0] a, b;
      logic e, o;
      int er0, idx;
      sample_a = 14'h1234; sample_b = 14'h0ABC;
      model_latch(a, b);
      push_frame(a, b, 1, 10);
      adc_conv(); adc_falls(10);
      er0 = err_cnt;
      sample_a = 14'h3001; sample_b = 14'h0F0F;
      model_latch(a, b);
      push_frame(a, b, 1, 34);
      adc_conv();
      n_checks++; if (err_cnt - er0 != 1) begin n_fail++; $display("FAIL abort frame_err pulses: got %0d expected 1", err_cnt - er0); end
      n_checks++; if (conv_count !== m_cnt) begin n_fail++; $display("FAIL abort conv_count early: got %0d expected %0d", conv_count, m_cnt); end
      adc_falls(33);
      n_checks++; if (conv_count !== m_cnt) begin n_fail++; $display("FAIL abort conv_count at 33: got %0d expected %0d", conv_count, m_cnt); end
      adc_falls(1);
      model_frame_done();
      idx = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL abort bit %0d: got %b expected %b", idx, o, e); end
         idx++;
      end
      n_checks++; if (conv_count !== m_cnt) begin n_fail++; $display("FAIL abort conv_count: got %0d expected %0d", conv_count, m_cnt); end
   endtask

   task automatic test_shdn();
      logic [DATA_W-1:0] a, b;
      logic e, o;
      int gv0, idx;
      AMP_SHDN = 1'b1; wait_clk(HALF);
      m_ga = 4'h0; m_gb = 4'h0;
      n_checks++; if ({gain_b, gain_a} !== 8'h00) begin n_fail++; $display("FAIL shdn gains: got %h expected 00", {gain_b, gain_a}); end
      gv0 = gv_cnt;
      push_echo(8); amp_xfer(8'hFF, 8);
      n_checks++; if ({gain_b, gain_a} !== 8'h00 || gv_cnt != gv0) begin n_fail++; $display("FAIL shdn write ignored: got gains %h pulses %0d expected 00 and 0", {gain_b, gain_a}, gv_cnt - gv0); end
      sample_a = 14'h3FFF; sample_b = 14'h2001;
      model_latch(a, b);
      push_frame(a, b, 1, 34);
      adc_conv(); adc_falls(34);
      model_frame_done();
      idx = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL shdn bit %0d: got %b expected %b", idx, o, e); end
         idx++;
      end
      n_checks++; if (conv_count !== m_cnt) begin n_fail++; $display("FAIL shdn conv_count: got %0d expected %0d", conv_count, m_cnt); end
      AMP_SHDN = 1'b0; wait_clk(HALF);
   endtask

   // Preamp write in the middle of an ADC frame, then an immediate second frame.
   task automatic test_back_to_back();
      logic [DATA_W-1:0] a, b;
      logic e, o;
      int er0, idx;
      er0 = err_cnt;
      sample_a = 14'h0F3C; sample_b = 14'h30C5;
      model_latch(a, b);
      push_frame(a, b, 1, 5);
      push_echo(8);
      push_frame(a, b, 6, 34);
      adc_conv(); adc_falls(5);
      amp_xfer(8'h5A, 8);
      m_gb = 4'h5; m_ga = 4'hA;
      adc_falls(29);
      model_frame_done();
      sample_a = 14'h2001; sample_b = 14'h1FFE;
      model_latch(a, b);
      push_frame(a, b, 1, 34);
      adc_conv(); adc_falls(34);
      model_frame_done();
      idx = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL back_to_back bit %0d: got %b expected %b", idx, o, e); end
         idx++;
      end
      n_checks++; if (conv_count !== m_cnt) begin n_fail++; $display("FAIL back_to_back conv_count: got %0d expected %0d", conv_count, m_cnt); end
      n_checks++; if ({gain_b, gain_a} !== 8'h5A) begin n_fail++; $display("FAIL back_to_back gains: got %h expected 5A", {gain_b, gain_a}); end
      n_checks++; if (err_cnt != er0) begin n_fail++; $display("FAIL back_to_back frame_err pulses: got %0d expected 0", err_cnt - er0); end
   endtask

   task automatic test_async_reset();
      adc_conv(); adc_falls(5);
      obs_q.delete();
      @(negedge clk); #2 rst = 1'b0; #1;
      n_checks++; if (conv_count !== 16'd0) begin n_fail++; $display("FAIL async reset conv_count: got %0d expected 0", conv_count); end
      n_checks++; if ({gain_b, gain_a} !== 8'h00) begin n_fail++; $display("FAIL async reset gains: got %h expected 00", {gain_b, gain_a}); end
      n_checks++; if (AD_DOUT !== 1'b0 || AMP_DOUT !== 1'b0) begin n_fail++; $display("FAIL async reset dout: got %b%b expected 00", AD_DOUT, AMP_DOUT); end
      n_checks++; if (gain_valid !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL async reset pulses: got %b%b expected 00", gain_valid, frame_err); end
      wait_clk(3); rst = 1'b1; wait_clk(3);
      m_cnt = 16'd0; m_ga = 4'h0; m_gb = 4'h0; m_ramp = '0;
      adc_falls(3);
      obs_q.delete();
      n_checks++; if (conv_count !== 16'd0 || AD_DOUT !== 1'b0) begin n_fail++; $display("FAIL post reset idle: got count %0d dout %b expected 0 0", conv_count, AD_DOUT); end
   endtask

   initial begin
      test_reset();
`ifdef ADC_RESP_RAMP_EN
      test_ramp();
`endif
      test_gain_write();
      test_adc_frame();
      test_abort();
      test_shdn();
      test_back_to_back();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
